pspin_pkt_ingress_arb: RTL and testbench

Round-robin arbiter that shares the PsPIN packet allocator's single ingress request port between `NUM_PORTS` matching-engine queues. Each queue presents a packet descriptor (tag, length). The arbiter grants one queue per cycle, registers the winning descriptor and drives it to the allocator under a valid/ready handshake. It also tags each descriptor with its source port so downstream DMA/statistics logic can attribute it.

---
 rtl/pspin_pkt_ingress_arb.sv | 126 ++++++++++++
 tb/tb_pspin_pkt_ingress_arb.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pspin_pkt_ingress_arb.sv
// Round-robin arbiter sharing the PsPIN allocator ingress port between NUM_PORTS queues.
// Optional per-port accept counters are built when PSPIN_PKT_ARB_STATS_EN is defined.
module pspin_pkt_ingress_arb #(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned LEN_WIDTH  = 20,
    parameter int unsigned TAG_WIDTH  = 8,
    parameter int unsigned PORT_WIDTH = $clog2(NUM_PORTS)
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [NUM_PORTS*TAG_WIDTH-1:0] s_pkt_idx_i,
    input  logic [NUM_PORTS*LEN_WIDTH-1:0] s_pkt_len_i,
    input  logic [NUM_PORTS-1:0]           s_pkt_valid_i,
    output logic [NUM_PORTS-1:0]           s_pkt_ready_o,
    output logic [TAG_WIDTH-1:0]           m_pkt_idx_o,
    output logic [LEN_WIDTH-1:0]           m_pkt_len_o,
    output logic [PORT_WIDTH-1:0]          m_pkt_port_o,
    output logic                           m_pkt_valid_o,
    input  logic                           m_pkt_ready_i,
    output logic [NUM_PORTS*32-1:0]        port_accepted_o
);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [PORT_WIDTH-1:0] r_rr;
    logic [PORT_WIDTH-1:0] r_port;
    logic [TAG_WIDTH-1:0]  r_idx;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [PORT_WIDTH-1:0] w_winner;
    logic [PORT_WIDTH-1:0] w_cand;
    logic                  w_any_valid;
    logic                  w_load;
    logic                  w_up_hs;
    logic [TAG_WIDTH-1:0]  w_sel_idx;
    logic [LEN_WIDTH-1:0]  w_sel_len;

    // Search starts one past the last granted port, so that port has the lowest priority.
    always_comb begin
        w_any_valid = 1'b0;
        w_winner    = r_rr;
        w_cand      = '0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            w_cand = PORT_WIDTH'((32'(r_rr) + k) % NUM_PORTS);
            if (!w_any_valid && s_pkt_valid_i[w_cand]) begin
                w_any_valid = 1'b1;
                w_winner    = w_cand;
            end
        end
    end

    assign w_load  = (r_state == StEmpty) || m_pkt_ready_i;
    assign w_up_hs = w_load && w_any_valid;

    always_comb begin
        s_pkt_ready_o = '0;
        if (w_up_hs) begin
            s_pkt_ready_o[w_winner] = 1'b1;
        end
    end

    always_comb begin
        w_sel_idx = s_pkt_idx_i[w_winner*TAG_WIDTH +: TAG_WIDTH];
        w_sel_len = s_pkt_len_i[w_winner*LEN_WIDTH +: LEN_WIDTH];
    end

    always_comb begin
        w_state_next = r_state;
        if (w_load) begin
            w_state_next = w_any_valid ? StFull : StEmpty;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= StEmpty;
            r_rr    <= PORT_WIDTH'(NUM_PORTS - 1);
            r_port  <= '0;
            r_idx   <= '0;
            r_len   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_up_hs) begin
                r_rr   <= w_winner;
                r_port <= w_winner;
                r_idx  <= w_sel_idx;
                r_len  <= w_sel_len;
            end
        end
    end

    assign m_pkt_valid_o = (r_state == StFull);
    assign m_pkt_idx_o   = r_idx;
    assign m_pkt_len_o   = r_len;
    assign m_pkt_port_o  = r_port;

`ifdef PSPIN_PKT_ARB_STATS_EN
    logic [31:0] r_cnt [NUM_PORTS];

    // Counters wrap silently at 2^32.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_up_hs && (w_winner == PORT_WIDTH'(i))) begin
                    r_cnt[i] <= r_cnt[i] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        port_accepted_o = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            port_accepted_o[i*32 +: 32] = r_cnt[i];
        end
    end
`else
    assign port_accepted_o = '0;
`endif

endmodule

// File: tb/tb_pspin_pkt_ingress_arb.sv
// Directed self-checking bench for pspin_pkt_ingress_arb (4 ports, default widths).
module tb_pspin_pkt_ingress_arb;

`ifdef PSPIN_PKT_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rstn;
    logic [31:0]  idx_v;
    logic [79:0]  len_v;
    logic [3:0]   valid_v;
    logic [3:0]   s_ready;
    logic [7:0]   m_idx;
    logic [19:0]  m_len;
    logic [1:0]   m_port;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] acc;

    int n_tests = 0;
    int n_fail  = 0;

    pspin_pkt_ingress_arb dut (
        .clk             (clk),
        .rstn            (rstn),
        .s_pkt_idx_i     (idx_v),
        .s_pkt_len_i     (len_v),
        .s_pkt_valid_i   (valid_v),
        .s_pkt_ready_o   (s_ready),
        .m_pkt_idx_o     (m_idx),
        .m_pkt_len_o     (m_len),
        .m_pkt_port_o    (m_port),
        .m_pkt_valid_o   (m_valid),
        .m_pkt_ready_i   (m_ready),
        .port_accepted_o (acc)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic v, input logic [7:0] id,
                            input logic [19:0] ln);
        valid_v[p]        = v;
        idx_v[p*8 +: 8]   = id;
        len_v[p*20 +: 20] = ln;
    endtask

    task automatic chk_out(input string tag, input logic [1:0] p, input logic [7:0] id,
                           input logic [19:0] ln);
        chk({tag, ".valid"}, 64'(m_valid), 64'd1);
        chk({tag, ".port"}, 64'(m_port), 64'(p));
        chk({tag, ".idx"}, 64'(m_idx), 64'(id));
        chk({tag, ".len"}, 64'(m_len), 64'(ln));
    endtask

    task automatic chk_cnt(input string tag, input int p, input int n);
        chk(tag, 64'(acc[p*32 +: 32]), STATS ? 64'(n) : 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
        #1;
    endtask

    initial begin
        rstn    = 1'b0;
        idx_v   = '0;
        len_v   = '0;
        valid_v = '0;
        m_ready = 1'b0;
        #2;
        chk("rst.valid", 64'(m_valid), 64'd0);
        chk("rst.idx", 64'(m_idx), 64'd0);
        chk("rst.len", 64'(m_len), 64'd0);
        chk("rst.port", 64'(m_port), 64'd0);
        chk("rst.acc", 64'(acc != 0), 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Single request from port 2.
        set_port(2, 1'b1, 8'h05, 20'd64);
        m_ready = 1'b1;
        #1;
        chk("p2.sready", 64'(s_ready), 64'b0100);
        step();
        chk_out("p2.out", 2'd2, 8'h05, 20'd64);
        chk_cnt("p2.cnt", 2, 1);
        set_port(2, 1'b0, 8'h05, 20'd64);
        step();
        chk("p2.drain", 64'(m_valid), 64'd0);

        // All ports requesting: strict 0,1,2,3 rotation.
        do_reset();
        for (int i = 0; i < 4; i++) set_port(i, 1'b1, 8'(8'h10 + i), 20'(100 + i));
        for (int n = 0; n < 8; n++) begin
            #1;
            chk($sformatf("all.sready%0d", n), 64'(s_ready), 64'(4'b0001 << (n % 4)));
            step();
            chk_out($sformatf("all.out%0d", n), 2'(n % 4), 8'(8'h10 + n % 4), 20'(100 + n % 4));
        end
        for (int i = 0; i < 4; i++) chk_cnt($sformatf("all.cnt%0d", i), i, 2);

        // Hold a port-1 descriptor with the allocator stalled.
        valid_v = '0;
        set_port(1, 1'b1, 8'h21, 20'd7);
        #1;
        chk("hold.load_sready", 64'(s_ready), 64'b0010);
        step();
        chk_out("hold.loaded", 2'd1, 8'h21, 20'd7);
        valid_v = '0;
        set_port(0, 1'b1, 8'h30, 20'd300);
        set_port(3, 1'b1, 8'h33, 20'd333);
        m_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            #1;
            chk($sformatf("hold.sready%0d", n), 64'(s_ready), 64'd0);
            step();
            chk_out($sformatf("hold.out%0d", n), 2'd1, 8'h21, 20'd7);
        end
        m_ready = 1'b1;
        #1;
        chk("hold.rel_sready3", 64'(s_ready), 64'b1000);
        step();
        chk_out("hold.rel3", 2'd3, 8'h33, 20'd333);
        chk("hold.rel_sready0", 64'(s_ready), 64'b0001);
        step();
        chk_out("hold.rel0", 2'd0, 8'h30, 20'd300);
        chk_cnt("hold.cnt0", 0, 3);
        chk_cnt("hold.cnt1", 1, 3);
        chk_cnt("hold.cnt2", 2, 2);
        chk_cnt("hold.cnt3", 3, 3);

        // Port 3 alone back-to-back, then wrap to port 0.
        set_port(0, 1'b0, 8'h30, 20'd300);
        for (int n = 0; n < 3; n++) begin
            #1;
            chk($sformatf("solo.sready%0d", n), 64'(s_ready), 64'b1000);
            step();
            chk_out($sformatf("solo.out%0d", n), 2'd3, 8'h33, 20'd333);
        end
        set_port(0, 1'b1, 8'h30, 20'd300);
        #1;
        chk("wrap.sready0", 64'(s_ready), 64'b0001);
        step();
        chk_out("wrap.out0", 2'd0, 8'h30, 20'd300);
        chk("wrap.sready3", 64'(s_ready), 64'b1000);
        step();
        chk_out("wrap.out3", 2'd3, 8'h33, 20'd333);
        chk_cnt("wrap.cnt0", 0, 4);
        chk_cnt("wrap.cnt3", 3, 7);

        // Asynchronous reset while FULL.
        rstn = 1'b0;
        #1;
        chk("arst.valid", 64'(m_valid), 64'd0);
        chk("arst.idx", 64'(m_idx), 64'd0);
        chk("arst.acc", 64'(acc != 0), 64'd0);
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) set_port(i, 1'b1, 8'(8'h40 + i), 20'(400 + i));
        #1;
        chk("arst.sready", 64'(s_ready), 64'b0001);
        step();
        chk_out("arst.out", 2'd0, 8'h40, 20'd400);
        chk_cnt("arst.cnt0", 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
